// File: rtl/bram_fifo.sv
// Single-clock FIFO on a registered-read dual-port BRAM, 1-cycle read latency.
// Define BRAM_FIFO_ERR_EN to add sticky ovf_o/udf_o error flags.
module bram_dual_re #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= r_mem[raddr_i];
  end
endmodule

module bram_fifo #(
  parameter int memSize_p = 6,
  parameter int XLEN      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [XLEN-1:0]      data_i,
  input  logic                 pop_i,
  output logic [XLEN-1:0]      data_o,
  output logic                 rvalid_o,
  output logic                 full_o,
  output logic                 empty_o,
`ifdef BRAM_FIFO_ERR_EN
  output logic                 ovf_o,
  output logic                 udf_o,
`endif
  output logic [memSize_p:0]   count_o
);
  localparam int CW    = memSize_p + 1;
  localparam int DEPTH = 1 << memSize_p;

  logic [memSize_p-1:0] r_wptr;
  logic [memSize_p-1:0] r_rptr;
  logic [CW-1:0]        r_count;
  logic                 r_full;
  logic                 r_empty;
  logic                 r_rvalid;
  logic                 w_push;
  logic                 w_pop;
  logic [CW-1:0]        w_cnt_nxt;

  // Acceptance uses the registered flags; reset masks both requests.
  assign w_push = rst_ni & push_i & ~r_full;
  assign w_pop  = rst_ni & pop_i  & ~r_empty;

  always_comb begin
    w_cnt_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_count + CW'(1);
      2'b01:   w_cnt_nxt = r_count - CW'(1);
      default: w_cnt_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_rvalid <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count  <= w_cnt_nxt;
      r_full   <= (w_cnt_nxt == CW'(DEPTH));
      r_empty  <= (w_cnt_nxt == '0);
      r_rvalid <= w_pop;
    end
  end

  bram_dual_re #(
    .AW (memSize_p),
    .DW (XLEN)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (w_push),
    .waddr_i (r_wptr),
    .wdata_i (data_i),
    .re_i    (w_pop),
    .raddr_i (r_rptr),
    .rdata_o (data_o)
  );

`ifdef BRAM_FIFO_ERR_EN
  logic r_ovf;
  logic r_udf;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (push_i && r_full)  r_ovf <= 1'b1;
      if (pop_i  && r_empty) r_udf <= 1'b1;
    end
  end

  assign ovf_o = r_ovf;
  assign udf_o = r_udf;
`endif

  assign rvalid_o = r_rvalid;
  assign full_o   = r_full;
  assign empty_o  = r_empty;
  assign count_o  = r_count;
endmodule

// File: tb/tb_bram_fifo.sv
// Randomized scoreboard bench for bram_fifo (depth 4) against a queue model.
`timescale 1ns/1ps
module tb_bram_fifo;
  localparam int MS = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        push_i;
  logic [31:0] data_i;
  logic        pop_i;
  logic [31:0] data_o;
  logic        rvalid_o;
  logic        full_o;
  logic        empty_o;
  logic [MS:0] count_o;
`ifdef BRAM_FIFO_ERR_EN
  logic        ovf_o;
  logic        udf_o;
`endif

  bram_fifo #(.memSize_p(MS), .XLEN(32)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .push_i   (push_i),
    .data_i   (data_i),
    .pop_i    (pop_i),
    .data_o   (data_o),
    .rvalid_o (rvalid_o),
    .full_o   (full_o),
    .empty_o  (empty_o),
`ifdef BRAM_FIFO_ERR_EN
    .ovf_o    (ovf_o),
    .udf_o    (udf_o),
`endif
    .count_o  (count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] mq[$];
  logic [31:0] exq[$];
  bit m_ovf = 0;
  bit m_udf = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every read pulse must match the oldest outstanding pop.
  always @(negedge clk) begin
    if (rvalid_o === 1'b1) begin
      if (exq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdata: got %0h expected none", data_o);
      end else begin
        chk("rdata", data_o, exq.pop_front());
      end
    end
  end

  task automatic step(input bit p, input logic [31:0] d,
                      input bit r, input bit rst = 1'b1);
    bit pa;
    bit ra;
    push_i = p;
    data_i = d;
    pop_i  = r;
    rst_ni = rst;
    pa = rst && p && (mq.size() < DEPTH);
    ra = rst && r && (mq.size() > 0);
    if (!rst) begin
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      if (p && !pa) m_ovf = 1;
      if (r && !ra) m_udf = 1;
      if (ra) exq.push_back(mq.pop_front());
      if (pa) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    chk("count", 32'(count_o), 32'(mq.size()));
    chk("full", 32'(full_o), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty_o), 32'(mq.size() == 0));
    chk("rvalid", 32'(rvalid_o), 32'(ra));
`ifdef BRAM_FIFO_ERR_EN
    chk("ovf", 32'(ovf_o), 32'(m_ovf));
    chk("udf", 32'(udf_o), 32'(m_udf));
`endif
  endtask

  initial begin
    push_i = 0;
    data_i = 0;
    pop_i  = 0;
    rst_ni = 0;
    step(0, 0, 0, 0);
    step(1, 32'h99, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 32'hA0 + i, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    step(0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 32'hE0 + i, 0);
    step(1, 32'hB0, 0);
    step(1, 32'hB0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    step(0, 0, 0);
    step(1, 32'hC0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 32'h10, 0);
    step(1, 32'h11, 0);
    for (int i = 0; i < 10; i++) step(1, 32'h12 + i, 1);
    for (int i = 0; i < 3; i++) step(1, 32'h30 + i, 0);
    step(0, 0, 0, 0);
    step(1, 32'hD0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 49) != 0));
    end
    step(0, 0, 0);
    step(0, 0, 0);
    chk("drained", 32'(exq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
